// File: rtl/adc128s022_pkg.sv
// Shared types and constants for the ADC128S022 SPI responder model.
// The frame is LEAD_ZEROS leading zeros followed by a 12-bit sample.
package adc128s022_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int FRAME_BITS_DEFAULT = 16;
    localparam int LEAD_ZEROS         = 4;
    localparam int SAMPLE_BITS        = 12;
    localparam int ADDR_FIRST_EDGE    = 2;
    localparam int ADDR_LAST_EDGE     = 4;

endpackage

// File: rtl/adc_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a single
// history flop that produces one-clk rise/fall pulses on the synchronized level.
module adc_sync_edge #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{IDLE_LEVEL}};
            prev  <= IDLE_LEVEL;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/adc128s022_responder.sv
// Slave-side model of an ADC128S022: shifts a stored 12-bit sample out on dout
// and latches the channel address from din for the following frame.
module adc128s022_responder
    import adc128s022_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = FRAME_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        din,
    output logic        dout,
    output logic        dout_oe,
    input  logic        smp_wr_en,
    input  logic [2:0]  smp_wr_ch,
    input  logic [11:0] smp_wr_data,
    output logic [2:0]  cur_ch,
    output logic [2:0]  next_ch,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam int CW      = $clog2(FRAME_BITS + 1);
    localparam int SR_BITS = LEAD_ZEROS + SAMPLE_BITS;

    logic cs_level_unused, cs_rise, cs_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic din_s, din_rise_unused, din_fall_unused;

    adc_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .async_in(cs_n),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    adc_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .async_in(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    adc_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_din (
        .clk(clk), .rst_n(rst_n), .async_in(din),
        .level(din_s), .rise(din_rise_unused), .fall(din_fall_unused)
    );

    state_t               state, state_nxt;
    logic [CW-1:0]        edge_count;
    logic [SR_BITS-1:0]   shreg;
    logic [SR_BITS-1:0]   load_word;
    logic [2:0]           pend_addr;
    logic [SAMPLE_BITS-1:0] smp_table [8];

    logic load, do_shift, do_count, capture, to_hold, finish, abort;

    assign load_word = {{LEAD_ZEROS{1'b0}}, smp_table[next_ch]};
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cs_n edges are tested first so they win over a coincident sclk edge.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        do_shift  = 1'b0;
        do_count  = 1'b0;
        capture   = 1'b0;
        to_hold   = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else if (sclk_rise) begin
                    do_count = 1'b1;
                    capture  = (edge_count >= CW'(ADDR_FIRST_EDGE)) &&
                               (edge_count <= CW'(ADDR_LAST_EDGE));
                    if (edge_count == CW'(FRAME_BITS - 1)) begin
                        state_nxt = HOLD;
                        to_hold   = 1'b1;
                    end
                end else if (sclk_fall && (edge_count != '0)) begin
                    do_shift = 1'b1;
                end
            end
            HOLD: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The load reads the table before this cycle's write, so a colliding
    // write to next_ch only shows up in the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout        <= 1'b0;
            dout_oe     <= 1'b0;
            cur_ch      <= 3'd0;
            next_ch     <= 3'd0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= 16'd0;
            edge_count  <= '0;
            shreg       <= '0;
            pend_addr   <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                smp_table[i] <= '0;
            end
        end else begin
            frame_done <= finish;
            frame_err  <= abort;
            if (smp_wr_en) begin
                smp_table[smp_wr_ch] <= smp_wr_data;
            end
            if (load) begin
                cur_ch     <= next_ch;
                shreg      <= load_word;
                dout       <= load_word[SR_BITS-1];
                dout_oe    <= 1'b1;
                edge_count <= '0;
                pend_addr  <= 3'd0;
            end
            if (do_count) begin
                edge_count <= edge_count + CW'(1);
            end
            if (capture) begin
                pend_addr <= {pend_addr[1:0], din_s};
            end
            if (to_hold) begin
                dout <= 1'b0;
            end
            if (do_shift) begin
                shreg <= {shreg[SR_BITS-2:0], 1'b0};
                dout  <= shreg[SR_BITS-2];
            end
            if (finish) begin
                next_ch     <= pend_addr;
                frame_count <= frame_count + 16'd1;
            end
            if (finish || abort) begin
                dout    <= 1'b0;
                dout_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc128s022_responder.sv
// Drives SPI frames into the responder and checks every sampled dout bit
// against a scoreboard built from a small model of the sample table.
module tb_adc128s022_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n;
    logic        sclk;
    logic        din;
    logic        dout;
    logic        dout_oe;
    logic        smp_wr_en;
    logic [2:0]  smp_wr_ch;
    logic [11:0] smp_wr_data;
    logic [2:0]  cur_ch;
    logic [2:0]  next_ch;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_count;
    logic        busy;

    always #5 clk = ~clk;

    adc128s022_responder #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .din(din),
        .dout(dout), .dout_oe(dout_oe),
        .smp_wr_en(smp_wr_en), .smp_wr_ch(smp_wr_ch), .smp_wr_data(smp_wr_data),
        .cur_ch(cur_ch), .next_ch(next_ch),
        .frame_done(frame_done), .frame_err(frame_err),
        .frame_count(frame_count), .busy(busy)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  wr_ch;
        logic [11:0] wr_data;
        logic [2:0]  addr;
        int          nsclk;
        logic [2:0]  exp_cur;
    } frame_vec_t;

    frame_vec_t  vecs [6];
    int          n_vectors    = 0;
    int          n_miscompares = 0;
    int          done_pulses  = 0;
    int          err_pulses   = 0;
    logic [11:0] model_table [8];
    logic [2:0]  model_next;
    logic [15:0] model_count;
    logic        exp_q [$];

    always @(negedge clk) begin
        if (frame_done) done_pulses++;
        if (frame_err)  err_pulses++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic writeSample(input logic [2:0] ch, input logic [11:0] data);
        @(negedge clk);
        smp_wr_en = 1'b1; smp_wr_ch = ch; smp_wr_data = data;
        @(negedge clk);
        smp_wr_en = 1'b0;
        model_table[ch] = data;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) model_table[i] = 12'h000;
        model_next  = 3'd0;
        model_count = 16'd0;
        exp_q.delete();
    endtask

    // mode 0: plain frame; 1: write to next_ch on the cs_n-fall detect cycle;
    // 2: write to the channel being shifted out in the middle of the frame.
    task automatic applyStimulus(input logic [2:0] addr, input int nsclk,
                                 input logic [2:0] exp_cur, input int mode,
                                 input logic [11:0] wdata);
        logic [15:0] word;
        logic [2:0]  ch;
        logic        exp_bit;
        ch   = model_next;
        word = {4'b0000, model_table[ch]};
        for (int i = 1; i <= nsclk; i++) begin
            exp_q.push_back((i <= 16) ? word[16-i] : 1'b0);
        end
        done_pulses = 0;
        err_pulses  = 0;
        @(negedge clk);
        cs_n = 1'b0;
        if (mode == 1) begin
            tick(2);
            smp_wr_en = 1'b1; smp_wr_ch = ch; smp_wr_data = wdata;
            @(negedge clk);
            smp_wr_en = 1'b0;
            model_table[ch] = wdata;
            tick(2);
        end else begin
            tick(5);
        end
        checkOutput("cur_ch", {29'd0, cur_ch}, {29'd0, exp_cur});
        checkOutput("busy", {31'd0, busy}, 32'd1);
        for (int i = 1; i <= nsclk; i++) begin
            sclk = 1'b0;
            din  = (i >= 3 && i <= 5) ? addr[5-i] : 1'b1;
            if (mode == 2 && i == 8) begin
                smp_wr_en = 1'b1; smp_wr_ch = ch; smp_wr_data = wdata;
                @(negedge clk);
                smp_wr_en = 1'b0;
                model_table[ch] = wdata;
                tick(4);
            end else begin
                tick(5);
            end
            sclk    = 1'b1;
            exp_bit = exp_q.pop_front();
            checkOutput($sformatf("dout rise %0d", i), {30'd0, dout_oe, dout},
                        {30'd0, 1'b1, exp_bit});
            tick(5);
        end
        tick(2);
        cs_n = 1'b1;
        din  = 1'b0;
        tick(6);
        if (nsclk >= 16) begin
            model_next  = addr;
            model_count = model_count + 16'd1;
        end
        checkOutput("frame_done pulses", done_pulses, (nsclk >= 16) ? 1 : 0);
        checkOutput("frame_err pulses", err_pulses, (nsclk >= 16) ? 0 : 1);
        checkOutput("next_ch", {29'd0, next_ch}, {29'd0, model_next});
        checkOutput("frame_count", {16'd0, frame_count}, {16'd0, model_count});
        checkOutput("idle oe/dout/busy", {29'd0, dout_oe, dout, busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{wr: 1'b1, wr_ch: 3'd0, wr_data: 12'hABC, addr: 3'd5, nsclk: 16, exp_cur: 3'd0};
        vecs[1] = '{wr: 1'b1, wr_ch: 3'd5, wr_data: 12'h5A5, addr: 3'd2, nsclk: 16, exp_cur: 3'd5};
        vecs[2] = '{wr: 1'b0, wr_ch: 3'd0, wr_data: 12'h000, addr: 3'd7, nsclk: 7,  exp_cur: 3'd2};
        vecs[3] = '{wr: 1'b1, wr_ch: 3'd2, wr_data: 12'hFFF, addr: 3'd1, nsclk: 18, exp_cur: 3'd2};
        vecs[4] = '{wr: 1'b1, wr_ch: 3'd1, wr_data: 12'h001, addr: 3'd6, nsclk: 16, exp_cur: 3'd1};
        vecs[5] = '{wr: 1'b1, wr_ch: 3'd6, wr_data: 12'hC3A, addr: 3'd0, nsclk: 16, exp_cur: 3'd6};

        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b1; din = 1'b0;
        smp_wr_en = 1'b0; smp_wr_ch = 3'd0; smp_wr_data = 12'h000;
        modelReset();
        tick(3);
        checkOutput("reset outputs", {dout, dout_oe, cur_ch, next_ch, frame_done, frame_err, busy},
                    13'd0);
        checkOutput("reset frame_count", {16'd0, frame_count}, 32'd0);
        rst_n = 1'b1;
        tick(3);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].wr) writeSample(vecs[v].wr_ch, vecs[v].wr_data);
            applyStimulus(vecs[v].addr, vecs[v].nsclk, vecs[v].exp_cur, 0, 12'h000);
        end

        // Collision with the load cycle: old value now, new value next frame.
        applyStimulus(3'd0, 16, 3'd0, 1, 12'h123);
        applyStimulus(3'd3, 16, 3'd0, 0, 12'h000);

        // Writing the live channel mid-frame must not disturb the frame.
        writeSample(3'd3, 12'h9C4);
        applyStimulus(3'd3, 16, 3'd3, 2, 12'h777);
        applyStimulus(3'd4, 16, 3'd3, 0, 12'h000);

        // Reset in the middle of a frame, after the 9th sclk rising edge.
        err_pulses = 0;
        @(negedge clk);
        cs_n = 1'b0;
        tick(5);
        for (int i = 1; i <= 9; i++) begin
            sclk = 1'b0;
            tick(5);
            sclk = 1'b1;
            tick(5);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("mid-frame reset outputs",
                    {dout, dout_oe, cur_ch, next_ch, frame_done, frame_err, busy}, 13'd0);
        checkOutput("mid-frame reset frame_count", {16'd0, frame_count}, 32'd0);
        cs_n = 1'b1;
        sclk = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        checkOutput("no frame_err on reset", err_pulses, 0);
        modelReset();
        applyStimulus(3'd2, 16, 3'd0, 0, 12'h000);

        // Counter wrap from 0xFFFF.
        writeSample(3'd2, 12'h3C9);
        @(negedge clk);
        force dut.frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count;
        model_count = 16'hFFFF;
        tick(2);
        checkOutput("preset frame_count", {16'd0, frame_count}, 32'h0000FFFF);
        applyStimulus(3'd1, 16, 3'd2, 0, 12'h000);
        checkOutput("wrapped frame_count", {16'd0, frame_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/adc128s022_responder.md
ADC128S022_RESPONDER -- requirements
Module: adc128s022_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, 2, synchronizer depth on cs_n/sclk/din (legal 2..3).
REQ-002 SHALL have parameter FRAME_BITS, 16, SCLK cycles per conversion frame.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset; one clock domain only.
REQ-005 cs_n  in  1  chip select from the SPI master, async to clk.
REQ-006 sclk  in  1  SPI clock from the master, async to clk, idles high.
REQ-007 din  in  1  control-register serial input from the master.
REQ-008 dout  out  1  conversion result, serial, MSB first.
REQ-009 dout_oe  out  1  high while dout is driven; low means high-Z at the pad.
REQ-010 smp_wr_en  in  1  write strobe into the channel sample table.
REQ-011 smp_wr_ch  in  3  channel written.
REQ-012 smp_wr_data  in  12  sample value written.
REQ-013 cur_ch  out  3  channel being shifted out in the current frame.
REQ-014 next_ch  out  3  channel latched for the next frame.
REQ-015 frame_done  out  1  one-clk pulse on a complete frame.
REQ-016 frame_err  out  1  one-clk pulse on an aborted frame.
REQ-017 frame_count  out  16  completed-frame counter, wraps 0xFFFF->0x0000.
REQ-018 busy  out  1  high in any state except IDLE.

Function
REQ-019 cs_n, sclk, din SHALL pass SYNC_STAGES flops then a one-flop edge detector; all protocol decisions use the synchronized signals.
REQ-020 Supported SCLK period SHALL be >= 8 clk periods with high and low phases each >= 4 clk.
REQ-021 FSM states: IDLE, SHIFT, HOLD; IDLE->SHIFT on cs_n falling edge; SHIFT->HOLD at the FRAME_BITS-th sclk rising edge; SHIFT or HOLD->IDLE on cs_n rising edge.
REQ-022 On IDLE->SHIFT: cur_ch<=next_ch, shift register<={4'b0, sample[next_ch]}, dout<=bit 15, dout_oe<=1, edge counter<=0.
REQ-023 Each sclk falling edge in SHIFT, except the first (before any rising edge), SHALL shift dout to the next lower bit; dout SHALL update 3 clk (SYNC_STAGES+1) after the pin edge.
REQ-024 Each sclk rising edge in SHIFT SHALL increment the edge counter; din captured at counts 2, 3, 4 (1-based clocks 3,4,5) SHALL form ADD2, ADD1, ADD0 of a pending address.
REQ-025 In HOLD, further sclk edges SHALL be ignored, counter frozen, dout driven 0.
REQ-026 cs_n rise from HOLD: next_ch<=pending address, frame_count+1, frame_done pulse.
REQ-027 cs_n rise from SHIFT (abort): next_ch, frame_count unchanged, frame_err pulse, pending address discarded.
REQ-028 On any return to IDLE: dout_oe<=0, dout<=0 in the same cycle.
REQ-029 Sample table SHALL be 8x12 registers, writable in any state; a write to cur_ch SHALL NOT alter the frame in progress.
REQ-030 A write coinciding with the IDLE->SHIFT cycle to channel next_ch SHALL load the pre-write value into the shift register.
REQ-031 cs_n fall and cs_n rise detected while sclk edges coincide: cs_n event SHALL take priority.

Reset
REQ-032 Async assert: state IDLE, dout 0, dout_oe 0, cur_ch 0, next_ch 0, frame_done 0, frame_err 0, frame_count 0, busy 0, sample table all 0, synchronizers to idle levels (cs_n 1, sclk 1, din 0).
REQ-033 Reset asserted mid-frame SHALL abort silently (no frame_err pulse); first frame after reset converts channel 0.

Structure
REQ-034 Package adc128s022_pkg SHALL hold the state enum, FRAME_BITS default, LEAD_ZEROS=4, ADDR_FIRST_EDGE=2, ADDR_LAST_EDGE=4.
REQ-035 One sub-module adc_sync_edge (synchronizer + rise/fall detect), instantiated for cs_n, sclk, din.

Verification
REQ-036 Reset, write ch0=0xABC, frame with din ADD=3'b101 -> dout 0000_1010_1011_1100, frame_done once, next_ch=5, frame_count=1.
REQ-037 Write ch5=0x5A5, second frame -> cur_ch=5, dout 0000_0101_1010_0101.
REQ-038 cs_n raised after 7 sclk cycles -> frame_err once, next_ch and frame_count unchanged, dout_oe 0.
REQ-039 18 sclk cycles in one frame -> bits 17-18 read 0, frame_done once, count+1 only.
REQ-040 smp_wr to next_ch on the cs_n-fall detect cycle -> old value shifted out; new value seen next frame.
REQ-041 rst_n low at sclk 9 -> all outputs at reset values same cycle, no frame_err; preset frame_count 0xFFFF + one frame -> 0x0000.
